// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Writer side of the byte-wide, big-endian instruction memory. It accepts
// 32-bit instruction words over a valid/ready stream and writes each one as
// four consecutive byte writes. The most significant byte goes to the lowest
// address, so the fetch stage reads the word back unchanged. It is used to
// preload program memory while the pipeline is held in reset.
//
// Parameters
//   MEM_BYTES    instruction memory size in bytes (multiple of 4)
//   ADDR_W       byte address width, clog2(MEM_BYTES)
//   BASE_ADDR    first byte address written after start (word aligned)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   start         in   one-cycle pulse that begins a load session
//   word_valid    in   word_data / word_last are valid
//   word_data     in   instruction word, bit 31 = MSB
//   word_last     in   final word of the session
//   word_ready    out  loader accepts a word this cycle
//   mem_we        out  byte write strobe to instruction memory
//   mem_addr      out  byte address of the write
//   mem_wdata     out  byte written
//   busy          out  session in progress (ACCEPT or WRITE)
//   done          out  session finished, held until the next start
//   overflow      out  a word was dropped because memory is full
//   words_loaded  out  words written during this session
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_loaded
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The pointer has one extra bit so that it can hold MEM_BYTES once the
    // last slot has been filled, which is what makes the full check work.
    localparam logic [ADDR_W:0] BASE_PTR  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(MEM_BYTES - 4);
    localparam logic [ADDR_W:0] WORD_STEP = (ADDR_W+1)'(4);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   ptr;
    logic [1:0]        idx;
    logic [31:0]       data_q;
    logic              last_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] count;
    logic              room;
    logic [7:0]        byte_sel;

    assign room = (ptr <= LAST_SLOT);

    // Big-endian byte lane: idx 0 carries bits 31:24.
    always_comb begin
        byte_sel = data_q[31:24];
        case (idx)
            2'd0:    byte_sel = data_q[31:24];
            2'd1:    byte_sel = data_q[23:16];
            2'd2:    byte_sel = data_q[15:8];
            default: byte_sel = data_q[7:0];
        endcase
    end

    // State register. An asynchronous reset returns to IDLE, so mem_we
    // drops immediately even in the middle of a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The outputs depend only on the state and on the
    // datapath registers, never on the inputs.
    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCEPT;
            end
            ACCEPT: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) state_next = room ? WRITE : DONE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr[ADDR_W-1:0] + ADDR_W'(idx);
                mem_wdata = byte_sel;
                if (idx == 2'd3) state_next = last_q ? DONE : ACCEPT;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = ACCEPT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the word buffer, the byte index, the write pointer, the word
    // count and the sticky overflow flag. A word that arrives when memory is
    // full is consumed but never buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= BASE_PTR;
            idx        <= 2'd0;
            data_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ptr        <= BASE_PTR;
                        count      <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (word_valid) begin
                        if (room) begin
                            data_q <= word_data;
                            last_q <= word_last;
                            idx    <= 2'd0;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        ptr   <= ptr + WORD_STEP;
                        count <= count + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign overflow     = overflow_q;
    assign words_loaded = count;

endmodule
